// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
// One operation in flight; results are handed off on a valid/ready writeback port.
// Divide runs as a restoring radix-2 loop on operand magnitudes. Multiply runs as a
// shift-add loop over a 64-bit accumulator. Both take 32 iterations and share the
// same working registers.
// Optional feature macro: RISK_MUL_EN. When it is defined, MUL/MULH/MULHSU/MULHU are
// implemented. When it is undefined, the multiply datapath is left out and those ops
// return wb_err=1 one cycle after accept.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err,
  output logic            busy
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;     // final result must be negated
  logic [XLEN-1:0]   a_q, a_d;         // divisor / multiplicand magnitude
  logic [XLEN-1:0]   r_q, r_d;         // partial remainder / product high half
  logic [XLEN-1:0]   q_q, q_d;         // dividend->quotient / multiplier->product low half
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              err_q, err_d;

  logic [XLEN-1:0]   abs1, abs2;
  logic              sgn_div;
  logic [XLEN:0]     r_sh, diff;
  logic [XLEN-1:0]   step_r, step_q;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
`ifdef RISK_MUL_EN
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod_fix;
`endif

  assign abs1    = req_rs1[XLEN-1] ? (~req_rs1 + 1'b1) : req_rs1;
  assign abs2    = req_rs2[XLEN-1] ? (~req_rs2 + 1'b1) : req_rs2;
  assign sgn_div = (req_op == OP_DIV) || (req_op == OP_REM);

  // One iteration of whichever algorithm the latched op selects
  always_comb begin
    r_sh   = {r_q, q_q[XLEN-1]};
    diff   = r_sh - {1'b0, a_q};
    step_r = r_q;
    step_q = q_q;
`ifdef RISK_MUL_EN
    sum    = '0;
`endif
    if (op_q[2]) begin
      // Remainder stays below the divisor, so a non-negative difference fits XLEN bits
      if (!diff[XLEN]) begin
        step_r = diff[XLEN-1:0];
        step_q = {q_q[XLEN-2:0], 1'b1};
      end else begin
        step_r = r_sh[XLEN-1:0];
        step_q = {q_q[XLEN-2:0], 1'b0};
      end
    end
`ifdef RISK_MUL_EN
    else begin
      // Add multiplicand into the high half when the multiplier LSB is set, then shift right
      sum    = {1'b0, r_q} + (q_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
      step_r = sum[XLEN:1];
      step_q = {sum[0], q_q[XLEN-1:1]};
    end
`endif
  end

  // Sign fix-up and result selection applied to the last iteration's output
  always_comb begin
    quo_fix = neg_q ? (~step_q + 1'b1) : step_q;
    rem_fix = neg_q ? (~step_r + 1'b1) : step_r;
`ifdef RISK_MUL_EN
    prod_fix = neg_q ? (~{step_r, step_q} + 1'b1) : {step_r, step_q};
`endif
    fin_res = '0;
    case (op_q)
      OP_DIV, OP_DIVU: fin_res = quo_fix;
      OP_REM, OP_REMU: fin_res = rem_fix;
`ifdef RISK_MUL_EN
      OP_MUL:          fin_res = prod_fix[XLEN-1:0];
      default:         fin_res = prod_fix[2*XLEN-1:XLEN];
`else
      default:         fin_res = '0;
`endif
    endcase
  end

  // Next-state, datapath loads and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    a_d       = a_q;
    r_d       = r_q;
    q_d       = q_q;
    rd_d      = rd_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = 1'b0;
    wb_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        // A request aimed at x0 is swallowed: nothing to write back
        if (req_valid && (req_rd != 5'd0)) begin
          op_d  = req_op;
          rd_d  = req_rd;
          err_d = 1'b0;
          r_d   = '0;
          cnt_d = '0;
          if (req_op[2]) begin
            if (req_rs2 == '0) begin
              // Divide by zero: quotient all ones, remainder is the dividend
              data_d  = req_op[1] ? req_rs1 : '1;
              state_d = DONE;
            end else if (sgn_div && (req_rs1 == MIN_NEG) && (req_rs2 == '1)) begin
              // Signed overflow: quotient is the dividend, remainder zero
              data_d  = req_op[1] ? '0 : MIN_NEG;
              state_d = DONE;
            end else begin
              a_d     = sgn_div ? abs2 : req_rs2;
              q_d     = sgn_div ? abs1 : req_rs1;
              // Quotient sign is the XOR of operand signs; remainder follows the dividend
              neg_d   = sgn_div & (req_op[1] ? req_rs1[XLEN-1]
                                             : (req_rs1[XLEN-1] ^ req_rs2[XLEN-1]));
              state_d = CALC;
            end
          end else begin
`ifdef RISK_MUL_EN
            a_d = ((req_op == OP_MULH) || (req_op == OP_MULHSU)) ? abs1 : req_rs1;
            q_d = (req_op == OP_MULH) ? abs2 : req_rs2;
            case (req_op)
              OP_MULH:   neg_d = req_rs1[XLEN-1] ^ req_rs2[XLEN-1];
              OP_MULHSU: neg_d = req_rs1[XLEN-1];
              default:   neg_d = 1'b0;   // MUL low half is sign-agnostic; MULHU unsigned
            endcase
            state_d = CALC;
`else
            data_d  = '0;
            err_d   = 1'b1;
            state_d = DONE;
`endif
          end
        end
      end
      CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          data_d  = fin_res;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      r_q     <= r_d;
      q_q     <= q_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign wb_rd   = rd_q;
  assign wb_data = data_q;
  assign wb_err  = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: fixed vector table, hand-written corner sequences
// (writeback stall, x0 destination, mid-operation reset), then random operations
// checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result and latency from the RV32M arithmetic rules
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.err = 1'b0;
    e.lat = 33;
    e.data = '0;
    p = '0;
    if (op[2]) begin
      if (b == 0) begin
        e.lat  = 1;
        e.data = op[1] ? a : 32'hFFFF_FFFF;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lat  = 1;
        e.data = op[1] ? 32'd0 : 32'h8000_0000;
      end else begin
        case (op)
          3'b100:  e.data = $signed(a) / $signed(b);
          3'b101:  e.data = a / b;
          3'b110:  e.data = $signed(a) % $signed(b);
          default: e.data = a % b;
        endcase
      end
    end else begin
`ifdef RISK_MUL_EN
      case (op)
        3'b000:  p = {32'd0, a} * {32'd0, b};
        3'b001:  p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        3'b010:  p = {{32{a[31]}}, a} * {32'd0, b};
        default: p = {32'd0, a} * {32'd0, b};
      endcase
      e.data = (op == 3'b000) ? p[31:0] : p[63:32];
`else
      e.lat  = 1;
      e.err  = 1'b1;
      e.data = '0;
`endif
    end
    return e;
  endfunction

  // Issue one op, wait (bounded) for writeback, then consume it
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] data, output logic err,
                       output logic [4:0] rdo, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    @(posedge clk); #1;
    // Scramble request inputs after accept; the unit must ignore them
    req_valid = 1'b0; req_op = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
    req_rd = 5'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!wb_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    data = wb_data; err = wb_err; rdo = wb_rd;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    chk("ready_after_handoff", {30'd0, req_ready, wb_valid}, 32'd2);
  endtask

  vec_t vecs[$];
  logic [31:0] d;
  logic        e;
  logic [4:0]  r;
  int          l;
  exp_t        ex;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    vecs.push_back('{3'b101, 32'd100,        32'd7,          5'd5,  32'd14,         1'b0, 33});
    vecs.push_back('{3'b111, 32'd100,        32'd7,          5'd6,  32'd2,          1'b0, 33});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  1'b0, 33});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  1'b0, 33});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1'b0, 1});
    vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1'b0, 1});
    vecs.push_back('{3'b101, 32'd55,         32'd0,          5'd11, 32'hFFFF_FFFF,  1'b0, 1});
    vecs.push_back('{3'b111, 32'd55,         32'd0,          5'd12, 32'd55,         1'b0, 1});
    vecs.push_back('{3'b110, 32'hFFFF_FFFB,  32'd0,          5'd13, 32'hFFFF_FFFB,  1'b0, 1});
    vecs.push_back('{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          1'b0, 33});
    vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE,  5'd15, 32'd1,          1'b0, 33});
`ifdef RISK_MUL_EN
    vecs.push_back('{3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd16, 32'd1,          1'b0, 33});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd17, 32'hFFFF_FFFE,  1'b0, 33});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd18, 32'd0,          1'b0, 33});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'd2,          5'd19, 32'hFFFF_FFFF,  1'b0, 33});
`else
    vecs.push_back('{3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd16, 32'd0,          1'b1, 1});
    vecs.push_back('{3'b011, 32'd3,          32'd4,          5'd17, 32'd0,          1'b1, 1});
`endif

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, d, e, r, l);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_rd", i), {27'd0, r}, {27'd0, vecs[i].rd});
      chk($sformatf("vec%0d_lat", i), l, vecs[i].exp_lat);
    end

    // Writeback stall: result and handshake must hold while wb_ready is low
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b101; req_rs1 = 32'd1000; req_rs2 = 32'd10; req_rd = 5'd3;
    @(posedge clk); #1;
    req_valid = 1'b0; req_rs1 = 32'd1;
    l = 1;
    while (!wb_valid && l < 64) begin @(posedge clk); #1; l++; end
    chk("stall_lat", l, 33);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, wb_valid}, 32'd1);
      chk("stall_data", wb_data, 32'd100);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    chk("stall_release_valid", {31'd0, wb_valid}, 32'd0);
    chk("stall_release_ready", {31'd0, req_ready}, 32'd1);

    // Destination x0: consumed, nothing computed or written back
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b101; req_rs1 = 32'd50; req_rs2 = 32'd5; req_rd = 5'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("x0_ready", {30'd0, req_ready, busy}, 32'd2);
      chk("x0_no_wb", {31'd0, wb_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a divide
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b101; req_rs1 = 32'hFFFF_FFFF; req_rs2 = 32'd3; req_rd = 5'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, wb_valid}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_data", wb_data, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_wb", {31'd0, wb_valid}, 32'd0);
    end
    do_op(3'b101, 32'd9, 32'd3, 5'd1, d, e, r, l);
    chk("postrst_data", d, 32'd3);
    chk("postrst_lat", l, 33);

    // Random operations against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(0, 20)); end
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      rd = 5'($urandom_range(1, 31));
      ex = model(op, a, b);
      do_op(op, a, b, rd, d, e, r, l);
      if (d !== ex.data || e !== ex.err || r !== rd || l != ex.lat) begin
        $display("FAIL rnd%0d op=%0d a=%h b=%h: got data=%h err=%0d rd=%0d lat=%0d expected data=%h err=%0d rd=%0d lat=%0d",
                 n, op, a, b, d, e, r, l, ex.data, ex.err, rd, ex.lat);
        bad++;
      end
      total++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
